// File: rtl/uart_reg_bridge.sv
`timescale 1ns/1ps
// UART-to-register-write bridge: 8N1 receiver feeding a checksummed frame parser
// that issues single-cycle register writes for FPGA debug of the timer peripheral.
module uart_reg_bridge #(
  parameter int CLK_HZ       = 27000000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              frame_err_o,
  output logic              busy_o
);
  localparam int DIV     = (CLK_HZ + BAUD/2) / BAUD;
  localparam int NB      = DATA_W / 8;
  localparam int CW      = $clog2(DIV + 1);
  localparam int TO_CLKS = TIMEOUT_BITS * DIV;
  localparam int TW      = $clog2(TO_CLKS + 1);
  localparam int NW      = $clog2(NB + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HDR, P_DATA, P_CHK} p_state_t;

  // Synchroniser and edge-detect flops idle high so reset never fakes a start edge
  logic rx_meta, rxs, rxs_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  rx_state_t      r_state, r_next;
  logic [CW-1:0]  r_cnt, r_cnt_nx;
  logic [2:0]     bit_idx, bit_idx_nx;
  logic [7:0]     shreg, shreg_nx;
  logic           byte_vld, byte_vld_nx, stop_err, stop_err_nx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= R_IDLE;
      r_cnt    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_vld <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      r_state  <= r_next;
      r_cnt    <= r_cnt_nx;
      bit_idx  <= bit_idx_nx;
      shreg    <= shreg_nx;
      byte_vld <= byte_vld_nx;
      stop_err <= stop_err_nx;
    end
  end

  always_comb begin
    r_next      = r_state;
    r_cnt_nx    = r_cnt;
    bit_idx_nx  = bit_idx;
    shreg_nx    = shreg;
    byte_vld_nx = 1'b0;
    stop_err_nx = 1'b0;
    if (r_state != R_IDLE && r_cnt != '0) r_cnt_nx = r_cnt - 1'b1;
    case (r_state)
      R_IDLE: begin
        if (rxs_d && !rxs) begin
          r_next   = R_START;
          r_cnt_nx = CW'(DIV/2);
        end
      end
      R_START: begin
        if (r_cnt == '0) begin
          if (!rxs) begin
            r_next     = R_DATA;
            r_cnt_nx   = CW'(DIV-1);
            bit_idx_nx = '0;
          end else begin
            r_next = R_IDLE;
          end
        end
      end
      R_DATA: begin
        if (r_cnt == '0) begin
          shreg_nx = {rxs, shreg[7:1]};
          r_cnt_nx = CW'(DIV-1);
          if (bit_idx == 3'd7) r_next = R_STOP;
          else bit_idx_nx = bit_idx + 3'd1;
        end
      end
      R_STOP: begin
        if (r_cnt == '0) begin
          r_next = R_IDLE;
          if (rxs) byte_vld_nx = 1'b1;
          else stop_err_nx = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  p_state_t        p_state, p_next;
  logic [ADDR_W-1:0] addr_q, addr_nx, wr_addr_nx;
  logic [DATA_W-1:0] data_q, data_nx, wr_data_nx;
  logic [7:0]      chk_q, chk_nx;
  logic [NW-1:0]   cnt_q, cnt_nx;
  logic [TW-1:0]   to_cnt, to_nx;
  logic            wr_en_nx, err_nx, busy_nx, timeout, hdr_ok;
  logic [6:0]      hdr_hi;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_state     <= P_HDR;
      addr_q      <= '0;
      data_q      <= '0;
      chk_q       <= '0;
      cnt_q       <= '0;
      to_cnt      <= TW'(TO_CLKS-1);
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      p_state     <= p_next;
      addr_q      <= addr_nx;
      data_q      <= data_nx;
      chk_q       <= chk_nx;
      cnt_q       <= cnt_nx;
      to_cnt      <= to_nx;
      wr_en_o     <= wr_en_nx;
      wr_addr_o   <= wr_addr_nx;
      wr_data_o   <= wr_data_nx;
      frame_err_o <= err_nx;
      busy_o      <= busy_nx;
    end
  end

  assign hdr_hi = shreg[6:0] >> ADDR_W;
  assign hdr_ok = shreg[7] && (hdr_hi == '0);

  always_comb begin
    p_next     = p_state;
    addr_nx    = addr_q;
    data_nx    = data_q;
    chk_nx     = chk_q;
    cnt_nx     = cnt_q;
    to_nx      = to_cnt;
    wr_en_nx   = 1'b0;
    err_nx     = 1'b0;
    wr_addr_nx = wr_addr_o;
    wr_data_nx = wr_data_o;
    timeout    = 1'b0;
    // Idle timer only runs inside a frame while the receiver waits for a start bit
    if (p_state == P_HDR || byte_vld) begin
      to_nx = TW'(TO_CLKS-1);
    end else if (r_state == R_IDLE) begin
      if (to_cnt == '0) timeout = 1'b1;
      else to_nx = to_cnt - 1'b1;
    end
    if (stop_err || timeout) begin
      err_nx = 1'b1;
      p_next = P_HDR;
    end else if (byte_vld) begin
      case (p_state)
        P_HDR: begin
          if (hdr_ok) begin
            addr_nx = shreg[ADDR_W-1:0];
            chk_nx  = shreg;
            cnt_nx  = '0;
            p_next  = P_DATA;
          end else begin
            err_nx = 1'b1;
          end
        end
        P_DATA: begin
          data_nx[8*int'(cnt_q) +: 8] = shreg;
          chk_nx = chk_q ^ shreg;
          if (cnt_q == NW'(NB-1)) p_next = P_CHK;
          else cnt_nx = cnt_q + 1'b1;
        end
        P_CHK: begin
          if (shreg == chk_q) begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = addr_q;
            wr_data_nx = data_q;
          end else begin
            err_nx = 1'b1;
          end
          p_next = P_HDR;
        end
        default: p_next = P_HDR;
      endcase
    end
    busy_nx = (p_next != P_HDR);
  end
endmodule

// File: tb/tb_uart_reg_bridge.sv
`timescale 1ns/1ps
// Bench for uart_reg_bridge: directed scenarios plus random frames checked against
// a frame-level model of write/error outcomes.
module tb_uart_reg_bridge;
  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        wr_en, frame_err, busy;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int err_cnt = 0;

  uart_reg_bridge #(.CLK_HZ(1000000), .BAUD(100000), .ADDR_W(4), .DATA_W(32),
                    .TIMEOUT_BITS(20)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .frame_err_o(frame_err), .busy_o(busy));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) wr_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish, expected finish within 5ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0; clks(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; clks(DIV);
    end
    rx = stop; clks(DIV);
    rx = 1'b1;
  endtask

  // Reference: checksum is XOR over header and all data bytes
  function automatic logic [7:0] frame_chk(input logic [7:0] hdr, input logic [31:0] d);
    logic [7:0] c = hdr;
    for (int i = 0; i < 4; i++) c ^= 8'((d >> (8*i)) & 32'hFF);
    return c;
  endfunction

  function automatic bit hdr_legal(input logic [7:0] h);
    return (h >= 8'd128) && ((int'(h) - 128) < 16);
  endfunction

  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] d, input logic [7:0] c);
    send_byte(hdr);
    for (int i = 0; i < 4; i++) send_byte(8'((d >> (8*i)) & 32'hFF));
    send_byte(c);
  endtask

  logic [3:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;

  initial begin
    int w0, e0, kind;
    logic [7:0] hdr, c;
    logic [31:0] d;

    clks(5); rst_n = 1'b1; clks(5);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);

    // 1: good frame, busy observed after header
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'h83); clks(2);
    check("t1_busy_after_hdr", busy, 1);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h8B); clks(5);
    exp_addr = 4'h3; exp_data = 32'h12345678;
    check("t1_wr_pulses", wr_cnt - w0, 1);
    check("t1_err_pulses", err_cnt - e0, 0);
    check("t1_addr", wr_addr, exp_addr);
    check("t1_data", wr_data, exp_data);
    check("t1_busy_end", busy, 0);

    // 2: bad checksum
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(8'h83, 32'h12345678, 8'h8C); clks(5);
    check("t2_wr_pulses", wr_cnt - w0, 0);
    check("t2_err_pulses", err_cnt - e0, 1);
    check("t2_addr_kept", wr_addr, exp_addr);
    check("t2_data_kept", wr_data, exp_data);

    // 3: illegal header then good frame
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'h05); clks(5);
    check("t3_hdr_err", err_cnt - e0, 1);
    send_frame(8'h83, 32'h12345678, 8'h8B); clks(5);
    check("t3_wr_pulses", wr_cnt - w0, 1);
    check("t3_err_total", err_cnt - e0, 1);

    // 4: framing error on second byte, then recovery
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'h83); send_byte(8'h78, 1'b0); clks(DIV);
    check("t4_stop_err", err_cnt - e0, 1);
    check("t4_busy_cleared", busy, 0);
    send_frame(8'h83, 32'h12345678, 8'h8B); clks(5);
    check("t4_wr_pulses", wr_cnt - w0, 1);
    check("t4_err_total", err_cnt - e0, 1);

    // 5: inter-byte timeout after about 200 idle clocks
    e0 = err_cnt;
    send_byte(8'h83); send_byte(8'h78); send_byte(8'h56);
    clks(150);
    check("t5_no_early_err", err_cnt - e0, 0);
    check("t5_busy_waiting", busy, 1);
    clks(100);
    check("t5_one_timeout", err_cnt - e0, 1);
    check("t5_busy_end", busy, 0);

    // 6: glitch rejection, reset mid-frame, recovery
    w0 = wr_cnt; e0 = err_cnt;
    rx = 1'b0; clks(3); rx = 1'b1; clks(30);
    check("t6_glitch_wr", wr_cnt - w0, 0);
    check("t6_glitch_err", err_cnt - e0, 0);
    check("t6_glitch_busy", busy, 0);
    send_byte(8'h83); send_byte(8'h78); clks(3);
    rst_n = 1'b0; clks(2);
    check("t6_rst_addr", wr_addr, 0);
    check("t6_rst_data", wr_data, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", frame_err, 0);
    rst_n = 1'b1; clks(5);
    exp_addr = '0; exp_data = '0;
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(8'h83, 32'h12345678, 8'h8B); clks(5);
    exp_addr = 4'h3; exp_data = 32'h12345678;
    check("t6_wr_pulses", wr_cnt - w0, 1);
    check("t6_addr", wr_addr, exp_addr);
    check("t6_data", wr_data, exp_data);

    // Back-to-back frames with no idle between any bytes
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(8'h8A, 32'hDEADBEEF, frame_chk(8'h8A, 32'hDEADBEEF));
    send_frame(8'h81, 32'h0BADF00D, frame_chk(8'h81, 32'h0BADF00D));
    clks(5);
    exp_addr = 4'h1; exp_data = 32'h0BADF00D;
    check("b2b_wr_pulses", wr_cnt - w0, 2);
    check("b2b_err_pulses", err_cnt - e0, 0);
    check("b2b_addr", wr_addr, exp_addr);
    check("b2b_data", wr_data, exp_data);

    // Random frames against the frame-level model
    for (int n = 0; n < 12; n++) begin
      w0 = wr_cnt; e0 = err_cnt;
      kind = $urandom_range(0, 2);
      d = $urandom;
      if (kind == 2) begin
        do hdr = 8'($urandom_range(0, 255)); while (hdr_legal(hdr));
        send_byte(hdr);
      end else begin
        hdr = 8'(128 + $urandom_range(0, 15));
        c = frame_chk(hdr, d);
        if (kind == 1) c ^= 8'($urandom_range(1, 255));
        send_frame(hdr, d, c);
      end
      clks(5);
      if (kind == 0) begin
        exp_addr = 4'(hdr - 8'd128);
        exp_data = d;
      end
      check("rnd_wr_pulses", wr_cnt - w0, (kind == 0) ? 1 : 0);
      check("rnd_err_pulses", err_cnt - e0, (kind == 0) ? 0 : 1);
      check("rnd_addr", wr_addr, exp_addr);
      check("rnd_data", wr_data, exp_data);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
